// File: rtl/bus_arb_defs.sv
// -----------------------------------------------------------------------------
// bus_arb_defs
// Shared definitions for the two-master system bus arbiter: FSM state
// encodings, master identifiers, the invalid-slave code and the slave
// select to one-hot enable decode.
// -----------------------------------------------------------------------------
package bus_arb_defs;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Master identifiers. The value doubles as the bus mux select.
    localparam logic MASTER_1 = 1'b0;
    localparam logic MASTER_2 = 1'b1;

    // slave_sel code that never addresses a real slave.
    localparam logic [1:0] SLAVE_INVALID = 2'd3;

    // Decode a slave select into the one-hot slave enable vector.
    // The invalid code decodes to no enable at all.
    function automatic logic [2:0] slave_onehot(input logic [1:0] sel);
        logic [2:0] en;
        case (sel)
            2'd0:    en = 3'b001;
            2'd1:    en = 3'b010;
            2'd2:    en = 3'b100;
            default: en = 3'b000;
        endcase
        return en;
    endfunction

endpackage : bus_arb_defs

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin chooser.
//
// Ports:
//   elig[1:0]   in   eligibility, bit 0 = master 1, bit 1 = master 2
//   last_grant  in   master that owned the bus last (loses a tie)
//   pick_id     out  chosen master (MASTER_1 / MASTER_2)
//   pick_valid  out  1 when at least one master is eligible
// -----------------------------------------------------------------------------
module rr_pick2
    import bus_arb_defs::*;
(
    input  logic [1:0] elig,
    input  logic       last_grant,
    output logic       pick_id,
    output logic       pick_valid
);

    // Choose the single eligible master, or on a tie the one that did not
    // hold the bus last.
    always_comb begin
        pick_id    = MASTER_1;
        pick_valid = 1'b0;
        case (elig)
            2'b01: begin
                pick_id    = MASTER_1;
                pick_valid = 1'b1;
            end
            2'b10: begin
                pick_id    = MASTER_2;
                pick_valid = 1'b1;
            end
            2'b11: begin
                pick_id    = ~last_grant;
                pick_valid = 1'b1;
            end
            default: begin
                pick_id    = MASTER_1;
                pick_valid = 1'b0;
            end
        endcase
    end

endmodule : rr_pick2

// File: rtl/bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m
// Central arbiter/sequencer for the shared system bus: two masters, up to
// three slaves. Grants ownership round-robin, drives the bus mux select and
// slave enables, counts burst beats to release the bus, and handles slave
// split/resume plus a per-beat timeout.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   m1_req/m2_req in   level bus requests
//   m*_slave_sel  in   target slave 0..2 (3 = invalid, never granted)
//   m*_burst_len  in   burst beats, 0 treated as 1
//   beat_done     in   one data beat completed this cycle
//   slave_split   in   addressed slave requests a split (DATA only)
//   slave_resume  in   split slave ready to resume (pulse)
//   m1_grant      out  master 1 owns the bus
//   m2_grant      out  master 2 owns the bus
//   bus_sel       out  mux select, 0 = master 1, 1 = master 2
//   slave_en      out  one-hot slave enable
//   arb_busy      out  arbiter not idle
//   arb_timeout   out  one-cycle pulse on a timeout abort
// -----------------------------------------------------------------------------
module bus_arbiter_2m
    import bus_arb_defs::*;
#(
    parameter int BURST_W = 5,
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m1_req,
    input  logic               m2_req,
    input  logic [1:0]         m1_slave_sel,
    input  logic [1:0]         m2_slave_sel,
    input  logic [BURST_W-1:0] m1_burst_len,
    input  logic [BURST_W-1:0] m2_burst_len,
    input  logic               beat_done,
    input  logic               slave_split,
    input  logic               slave_resume,
    output logic               m1_grant,
    output logic               m2_grant,
    output logic               bus_sel,
    output logic [2:0]         slave_en,
    output logic               arb_busy,
    output logic               arb_timeout
);

    localparam logic [BURST_W-1:0] LEN_ONE  = BURST_W'(1);
    localparam logic [BURST_W-1:0] LEN_ZERO = {BURST_W{1'b0}};
    localparam logic [TO_W-1:0]    TO_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]    TO_ONE   = TO_W'(1);
    // Last idle count before the abort fires: the abort happens on the
    // TIMEOUT-th consecutive DATA cycle without a beat.
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);

    // FSM and burst state.
    arb_state_t         state_r;
    logic               owner_r;
    logic [1:0]         slave_r;
    logic [BURST_W-1:0] len_r;
    logic [BURST_W-1:0] beat_cnt_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic               last_grant_r;

    // Split record.
    logic               split_valid_r;
    logic               split_master_r;
    logic [1:0]         split_slave_r;
    logic [BURST_W-1:0] split_rem_r;
    logic               resume_pending_r;

    // Registered outputs.
    logic               m1_grant_r;
    logic               m2_grant_r;
    logic               bus_sel_r;
    logic [2:0]         slave_en_r;
    logic               arb_busy_r;
    logic               arb_timeout_r;

    // Arbitration decision.
    logic [1:0]         elig_s;
    logic               rr_id_s;
    logic               rr_valid_s;
    logic               pick_go_s;
    logic               pick_owner_s;
    logic [1:0]         pick_slave_s;
    logic [BURST_W-1:0] pick_raw_len_s;
    logic [BURST_W-1:0] pick_len_s;
    logic               pick_resume_s;

    // Eligibility: valid target, not the split master, and not aiming at the
    // slave that is holding a split transaction.
    always_comb begin
        elig_s = 2'b00;
        if (m1_req && (m1_slave_sel != SLAVE_INVALID) &&
            !(split_valid_r && ((split_master_r == MASTER_1) ||
                                (m1_slave_sel == split_slave_r)))) begin
            elig_s[0] = 1'b1;
        end else begin
            elig_s[0] = 1'b0;
        end
        if (m2_req && (m2_slave_sel != SLAVE_INVALID) &&
            !(split_valid_r && ((split_master_r == MASTER_2) ||
                                (m2_slave_sel == split_slave_r)))) begin
            elig_s[1] = 1'b1;
        end else begin
            elig_s[1] = 1'b0;
        end
    end

    rr_pick2 u_rr_pick2 (
        .elig       (elig_s),
        .last_grant (last_grant_r),
        .pick_id    (rr_id_s),
        .pick_valid (rr_valid_s)
    );

    // Grant candidate: a resumed split master pre-empts round-robin and is
    // granted regardless of its current request.
    always_comb begin
        pick_go_s      = 1'b0;
        pick_owner_s   = MASTER_1;
        pick_slave_s   = 2'd0;
        pick_raw_len_s = LEN_ONE;
        pick_resume_s  = 1'b0;
        if (split_valid_r && resume_pending_r) begin
            pick_go_s      = 1'b1;
            pick_owner_s   = split_master_r;
            pick_slave_s   = split_slave_r;
            pick_raw_len_s = split_rem_r;
            pick_resume_s  = 1'b1;
        end else if (rr_valid_s) begin
            pick_go_s    = 1'b1;
            pick_owner_s = rr_id_s;
            if (rr_id_s == MASTER_2) begin
                pick_slave_s   = m2_slave_sel;
                pick_raw_len_s = m2_burst_len;
            end else begin
                pick_slave_s   = m1_slave_sel;
                pick_raw_len_s = m1_burst_len;
            end
        end else begin
            pick_go_s = 1'b0;
        end
    end

    // A zero-length request is a single beat.
    always_comb begin
        if (pick_raw_len_s == LEN_ZERO) begin
            pick_len_s = LEN_ONE;
        end else begin
            pick_len_s = pick_raw_len_s;
        end
    end

    // Arbiter FSM: grant, address phase, beat counting, split and timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            owner_r          <= MASTER_1;
            slave_r          <= 2'd0;
            len_r            <= LEN_ZERO;
            beat_cnt_r       <= LEN_ZERO;
            to_cnt_r         <= TO_ZERO;
            last_grant_r     <= MASTER_2;
            split_valid_r    <= 1'b0;
            split_master_r   <= MASTER_1;
            split_slave_r    <= 2'd0;
            split_rem_r      <= LEN_ZERO;
            resume_pending_r <= 1'b0;
            m1_grant_r       <= 1'b0;
            m2_grant_r       <= 1'b0;
            bus_sel_r        <= 1'b0;
            slave_en_r       <= 3'b000;
            arb_busy_r       <= 1'b0;
            arb_timeout_r    <= 1'b0;
        end else begin
            arb_timeout_r <= 1'b0;
            // A resume with no split outstanding is meaningless and dropped.
            if (slave_resume && split_valid_r) begin
                resume_pending_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (pick_go_s) begin
                        state_r    <= ST_ADDR;
                        owner_r    <= pick_owner_s;
                        slave_r    <= pick_slave_s;
                        len_r      <= pick_len_s;
                        m1_grant_r <= (pick_owner_s == MASTER_1);
                        m2_grant_r <= (pick_owner_s == MASTER_2);
                        bus_sel_r  <= pick_owner_s;
                        slave_en_r <= slave_onehot(pick_slave_s);
                        arb_busy_r <= 1'b1;
                        if (pick_resume_s) begin
                            split_valid_r    <= 1'b0;
                            resume_pending_r <= 1'b0;
                        end
                    end
                end

                ST_ADDR: begin
                    state_r    <= ST_DATA;
                    beat_cnt_r <= LEN_ZERO;
                    to_cnt_r   <= TO_ZERO;
                end

                ST_DATA: begin
                    if (slave_split) begin
                        // Split beats a coincident beat_done: the beat is
                        // redone after resume.
                        split_valid_r  <= 1'b1;
                        split_master_r <= owner_r;
                        split_slave_r  <= slave_r;
                        split_rem_r    <= len_r - beat_cnt_r;
                        state_r        <= ST_IDLE;
                        m1_grant_r     <= 1'b0;
                        m2_grant_r     <= 1'b0;
                        bus_sel_r      <= 1'b0;
                        slave_en_r     <= 3'b000;
                        arb_busy_r     <= 1'b0;
                    end else if (beat_done) begin
                        to_cnt_r <= TO_ZERO;
                        if (beat_cnt_r == (len_r - LEN_ONE)) begin
                            state_r      <= ST_IDLE;
                            last_grant_r <= owner_r;
                            m1_grant_r   <= 1'b0;
                            m2_grant_r   <= 1'b0;
                            bus_sel_r    <= 1'b0;
                            slave_en_r   <= 3'b000;
                            arb_busy_r   <= 1'b0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + LEN_ONE;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r       <= ST_IDLE;
                        last_grant_r  <= owner_r;
                        arb_timeout_r <= 1'b1;
                        m1_grant_r    <= 1'b0;
                        m2_grant_r    <= 1'b0;
                        bus_sel_r     <= 1'b0;
                        slave_en_r    <= 3'b000;
                        arb_busy_r    <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    m1_grant_r <= 1'b0;
                    m2_grant_r <= 1'b0;
                    bus_sel_r  <= 1'b0;
                    slave_en_r <= 3'b000;
                    arb_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign m1_grant    = m1_grant_r;
    assign m2_grant    = m2_grant_r;
    assign bus_sel     = bus_sel_r;
    assign slave_en    = slave_en_r;
    assign arb_busy    = arb_busy_r;
    assign arb_timeout = arb_timeout_r;

endmodule : bus_arbiter_2m

// File: tb/tb_bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Directed, table-driven bench for bus_arbiter_2m (TIMEOUT reduced to 10).
// Each vector holds the inputs applied before a rising edge and the output
// word expected just after it:
//   {m1_grant, m2_grant, bus_sel, slave_en[2:0], arb_busy, arb_timeout}
// -----------------------------------------------------------------------------
module tb_bus_arbiter_2m;

    localparam int BW = 5;

    // Expected output words.
    localparam logic [7:0] O_IDLE = 8'b000_000_0_0;
    localparam logic [7:0] O_TO   = 8'b000_000_0_1;
    localparam logic [7:0] M1_S0  = 8'b100_001_1_0;
    localparam logic [7:0] M1_S1  = 8'b100_010_1_0;
    localparam logic [7:0] M1_S2  = 8'b100_100_1_0;
    localparam logic [7:0] M2_S0  = 8'b011_001_1_0;
    localparam logic [7:0] M2_S1  = 8'b011_010_1_0;
    localparam logic [7:0] M2_S2  = 8'b011_100_1_0;

    logic          clk = 1'b0;
    logic          reset;
    logic          m1_req, m2_req;
    logic [1:0]    m1_slave_sel, m2_slave_sel;
    logic [BW-1:0] m1_burst_len, m2_burst_len;
    logic          beat_done, slave_split, slave_resume;
    logic          m1_grant, m2_grant, bus_sel, arb_busy, arb_timeout;
    logic [2:0]    slave_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst;
        logic          r1;
        logic          r2;
        logic [1:0]    s1;
        logic [1:0]    s2;
        logic [BW-1:0] l1;
        logic [BW-1:0] l2;
        logic          bd;
        logic          sp;
        logic          rs;
        logic [7:0]    exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bus_arbiter_2m #(.BURST_W(BW), .TIMEOUT(10), .TO_W(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .m1_req       (m1_req),
        .m2_req       (m2_req),
        .m1_slave_sel (m1_slave_sel),
        .m2_slave_sel (m2_slave_sel),
        .m1_burst_len (m1_burst_len),
        .m2_burst_len (m2_burst_len),
        .beat_done    (beat_done),
        .slave_split  (slave_split),
        .slave_resume (slave_resume),
        .m1_grant     (m1_grant),
        .m2_grant     (m2_grant),
        .bus_sel      (bus_sel),
        .slave_en     (slave_en),
        .arb_busy     (arb_busy),
        .arb_timeout  (arb_timeout)
    );

    function automatic vec_t mk(input logic rst, input logic r1, input logic r2,
                                input logic [1:0] s1, input logic [1:0] s2,
                                input logic [BW-1:0] l1, input logic [BW-1:0] l2,
                                input logic bd, input logic sp, input logic rs,
                                input logic [7:0] exp);
        vec_t v;
        v.rst = rst; v.r1 = r1; v.r2 = r2; v.s1 = s1; v.s2 = s2;
        v.l1 = l1; v.l2 = l2; v.bd = bd; v.sp = sp; v.rs = rs; v.exp = exp;
        return v;
    endfunction

    // Drive one vector, clock it in, then compare the outputs 1 ns later.
    task automatic run(input vec_t v, input string name);
        logic [7:0] act;
        reset        = v.rst;
        m1_req       = v.r1;
        m2_req       = v.r2;
        m1_slave_sel = v.s1;
        m2_slave_sel = v.s2;
        m1_burst_len = v.l1;
        m2_burst_len = v.l2;
        beat_done    = v.bd;
        slave_split  = v.sp;
        slave_resume = v.rs;
        @(posedge clk);
        #1;
        act = {m1_grant, m2_grant, bus_sel, slave_en, arb_busy, arb_timeout};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (g1 g2 sel en[2:0] busy to)",
                     name, act, v.exp);
        end
    endtask

    // Watchdog: the bench is purely step-driven, this only guards a stall.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- table: single request, contention, len 0, invalid
        // single: m1 -> slave 1, len 4, beat_done held high (ignored in ADDR)
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, O_IDLE));
        vecs.push_back(mk(0,1,0,1,0,4,0,1,0,0, M1_S1));   // granted, ADDR
        vecs.push_back(mk(0,1,0,1,0,4,0,1,0,0, M1_S1));   // -> DATA
        vecs.push_back(mk(0,1,0,1,0,4,0,1,0,0, M1_S1));   // beat 1
        vecs.push_back(mk(0,1,0,1,0,4,0,1,0,0, M1_S1));   // beat 2
        vecs.push_back(mk(0,1,0,1,0,4,0,1,0,0, M1_S1));   // beat 3
        vecs.push_back(mk(0,1,0,1,0,4,0,1,0,0, O_IDLE));  // beat 4 -> release
        vecs.push_back(mk(0,0,0,1,0,4,0,0,0,0, O_IDLE));
        // contention: both to slave 1, len 2, held; expect m1, m2, m1
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, O_IDLE));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M1_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M1_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M1_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, O_IDLE));  // idle gap
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M2_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M2_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M2_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, O_IDLE));  // idle gap
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M1_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M1_S1));
        vecs.push_back(mk(0,1,1,1,1,2,2,1,0,0, M1_S1));
        vecs.push_back(mk(0,0,0,1,1,2,2,1,0,0, O_IDLE));
        vecs.push_back(mk(0,0,0,1,1,2,2,0,0,0, O_IDLE));
        // len 0 behaves as one beat
        vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0, M1_S0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0, M1_S0));   // -> DATA
        vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0, M1_S0));   // no beat yet
        vecs.push_back(mk(0,1,0,0,0,0,0,1,0,0, O_IDLE));  // single beat ends it
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, O_IDLE));
        // slave_sel 3 never granted
        vecs.push_back(mk(0,0,1,0,3,0,2,0,0,0, O_IDLE));
        vecs.push_back(mk(0,0,1,0,3,0,2,0,0,0, O_IDLE));
        vecs.push_back(mk(0,1,1,3,3,2,2,0,0,0, O_IDLE));
        vecs.push_back(mk(0,1,1,2,3,1,2,0,0,0, M1_S2));   // valid m1 wins
        vecs.push_back(mk(0,1,1,2,3,1,2,0,0,0, M1_S2));
        vecs.push_back(mk(0,1,1,2,3,1,2,1,0,0, O_IDLE));
        vecs.push_back(mk(0,0,1,2,3,1,2,0,0,0, O_IDLE));

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // ---------------- split / resume: m1 slave 1 len 8, split after 3
        run(mk(1,0,0,0,0,0,0,0,0,0, O_IDLE), "split_rst");
        run(mk(0,1,0,1,0,8,0,0,0,0, M1_S1), "split_grant");
        run(mk(0,1,0,1,0,8,0,0,0,0, M1_S1), "split_addr");
        for (int b = 1; b <= 3; b++) begin
            run(mk(0,1,0,1,0,8,0,1,0,0, M1_S1), $sformatf("split_beat%0d", b));
        end
        run(mk(0,1,1,1,1,8,2,0,1,0, O_IDLE), "split_take");
        run(mk(0,1,1,1,1,8,2,0,0,0, O_IDLE), "split_m2_refused_a");
        run(mk(0,1,1,1,1,8,2,0,0,0, O_IDLE), "split_m2_refused_b");
        run(mk(0,1,1,1,0,8,2,0,0,0, M2_S0), "split_m2_grant");
        run(mk(0,1,1,1,0,8,2,0,0,0, M2_S0), "split_m2_addr");
        run(mk(0,1,1,1,0,8,2,1,0,0, M2_S0), "split_m2_beat1");
        run(mk(0,1,1,1,0,8,2,1,0,1, O_IDLE), "split_m2_done_resume");
        run(mk(0,1,1,1,0,8,2,0,0,0, M1_S1), "resume_m1_first");
        run(mk(0,0,1,1,0,8,2,0,0,0, M1_S1), "resume_addr");
        for (int b = 1; b <= 4; b++) begin
            run(mk(0,0,1,1,0,8,2,1,0,0, M1_S1), $sformatf("resume_beat%0d", b));
        end
        run(mk(0,0,1,1,0,8,2,1,0,0, O_IDLE), "resume_beat5_done");
        run(mk(0,0,1,1,0,8,2,0,0,0, M2_S0), "after_resume_m2");
        run(mk(0,0,1,1,0,8,2,0,0,0, M2_S0), "after_resume_addr");
        run(mk(0,0,1,1,0,8,2,1,0,0, M2_S0), "after_resume_b1");
        run(mk(0,0,0,1,0,8,2,1,0,0, O_IDLE), "after_resume_done");

        // ---------------- timeout: m2 slave 2, no beats
        run(mk(1,0,0,0,0,0,0,0,0,0, O_IDLE), "to_rst");
        run(mk(0,0,1,0,2,0,3,0,0,0, M2_S2), "to_grant");
        run(mk(0,0,1,0,2,0,3,0,0,0, M2_S2), "to_addr");
        for (int c = 1; c <= 9; c++) begin
            run(mk(0,0,1,0,2,0,3,0,0,0, M2_S2), $sformatf("to_wait%0d", c));
        end
        run(mk(0,0,0,0,2,0,3,0,0,0, O_TO), "to_pulse");
        run(mk(0,0,0,0,2,0,3,0,0,0, O_IDLE), "to_pulse_end");

        // ---------------- split coincident with final beat: remaining = 1
        run(mk(1,0,0,0,0,0,0,0,0,0, O_IDLE), "sf_rst");
        run(mk(0,1,0,0,0,2,0,0,0,0, M1_S0), "sf_grant");
        run(mk(0,1,0,0,0,2,0,0,0,0, M1_S0), "sf_addr");
        run(mk(0,1,0,0,0,2,0,1,0,0, M1_S0), "sf_beat1");
        run(mk(0,1,0,0,0,2,0,1,1,0, O_IDLE), "sf_split_wins");
        run(mk(0,1,1,0,0,2,1,0,0,0, O_IDLE), "sf_both_refused");
        run(mk(0,1,1,0,0,2,1,0,0,1, O_IDLE), "sf_resume_pulse");
        run(mk(0,1,1,0,0,2,1,0,0,0, M1_S0), "sf_regrant");
        run(mk(0,1,1,0,0,2,1,0,0,0, M1_S0), "sf_addr2");
        run(mk(0,1,1,0,0,2,1,1,0,0, O_IDLE), "sf_one_beat_left");
        run(mk(0,0,1,0,0,2,1,0,0,0, M2_S0), "sf_m2_after");

        // ---------------- reset mid-burst at beat 2
        run(mk(1,0,0,0,0,0,0,0,0,0, O_IDLE), "rm_rst");
        run(mk(0,1,0,2,0,4,0,0,0,0, M1_S2), "rm_grant");
        run(mk(0,1,0,2,0,4,0,0,0,0, M1_S2), "rm_addr");
        run(mk(0,1,0,2,0,4,0,1,0,0, M1_S2), "rm_beat1");
        run(mk(0,1,0,2,0,4,0,1,0,0, M1_S2), "rm_beat2");
        run(mk(1,1,1,2,2,4,4,1,0,0, O_IDLE), "rm_reset");
        run(mk(0,1,1,2,2,4,4,0,0,0, M1_S2), "rm_m1_wins_tie");
        run(mk(0,1,1,2,2,4,4,0,0,0, M1_S2), "rm_addr2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_arbiter_2m

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Central arbiter/sequencer for the shared system bus serving two masters and up to three slaves.
- Grants bus ownership round-robin and drives the bus mux select and slave enables.
- Counts burst beats to release the bus, and handles slave split/resume plus a per-beat timeout.
- Sits in top_level between the master ports and the bus mux/decoder.

Parameters:
- BURST_W, 5, width of burst length and beat counter (max 31 beats).
- TIMEOUT, 1000, cycles without beat_done in DATA before abort.
- TO_W, 10, timeout counter width (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- m1_req  in  1  master 1 bus request, level, held until granted burst ends
- m2_req  in  1  master 2 bus request
- m1_slave_sel  in  2  master 1 target slave (0..2; 3 = invalid)
- m2_slave_sel  in  2  master 2 target slave
- m1_burst_len  in  BURST_W  master 1 beats; 0 treated as 1
- m2_burst_len  in  BURST_W  master 2 beats
- beat_done  in  1  one data beat completed on bus this cycle
- slave_split  in  1  addressed slave requests split (valid in DATA only)
- slave_resume  in  1  pulse: split slave ready to resume
- m1_grant  out  1  master 1 owns bus
- m2_grant  out  1  master 2 owns bus
- bus_sel  out  1  mux select, 0 = master 1, 1 = master 2
- slave_en  out  3  one-hot slave enable
- arb_busy  out  1  state != IDLE
- arb_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (sync): state IDLE; all outputs 0; last_grant = master 2, so master 1 wins the first tie; split_valid 0; counters 0.
- States: IDLE, ADDR, DATA.
- IDLE: evaluate eligible requests.
  - A master is eligible if its req=1, its slave_sel != 3, it is not the split master, and its slave_sel != split_slave while split_valid.
  - Exception: the split master becomes top priority once resumed (see Split).
- Arbitration:
  - Both eligible: grant the one not equal to last_grant.
  - One eligible: grant it.
  - None eligible: stay in IDLE.
  - On grant: latch owner, slave, and len (0 becomes 1). Go to ADDR next cycle.
- Grant timing:
  - Grant, bus_sel and slave_en are registered and asserted from the first ADDR cycle.
  - Latency from req sampled in IDLE to grant visible is 1 cycle.
- ADDR: lasts exactly 1 cycle, then DATA; the beat counter clears.
- DATA: each beat_done increments the counter and reloads the timeout counter.
  - If beat_done and count == len-1: go to IDLE; grant, slave_en and arb_busy drop in the following cycle; last_grant = owner.
- IDLE lasts a minimum of 1 cycle between bursts (no back-to-back grant).
- Split:
  - If slave_split in DATA (has precedence over beat_done the same cycle): record split_master = owner, split_slave, and remaining beats = len - count. Set split_valid and go to IDLE.
  - The other master may be granted to other slaves.
  - On slave_resume (any state), set resume_pending. The next IDLE arbitration grants split_master unconditionally with len = remaining beats. split_valid and resume_pending clear at that grant.
  - slave_resume while split_valid=0 is ignored.
- Timeout:
  - In DATA, the counter increments each cycle without beat_done.
  - Reaching TIMEOUT: go to IDLE, arb_timeout = 1 for one cycle, last_grant = owner, no split recorded.
- Request dropped mid-burst: ignored; the burst runs to completion, split, or timeout.
- Invalid slave_sel (3): never granted; the arbiter stays in IDLE if that is the only request.
- Reset mid-operation: returns to reset values on the next edge; the split record is lost.

Decomposition:
- Shared package/header bus_arb_defs: state encodings (IDLE=0, ADDR=1, DATA=2), master IDs, SLAVE_INVALID=2'd3.
- One natural sub-module: rr_pick2, a combinational round-robin chooser taking eligibility[1:0] and last_grant and returning a grant ID and valid.
- The rest (FSM, counters, split record) stays in bus_arbiter_2m.

Test Plan:
- Single request: m1_req=1, slave 1, len 4, beat_done every cycle.
  - m1_grant rises 1 cycle after req, slave_en=3'b010, bus_sel=0.
  - Grant falls the cycle after the 4th beat; arb_busy tracks.
- Contention: m1 and m2 request slave 1 simultaneously, len 2, held.
  - Order m1, m2, m1 (round-robin), with 1 IDLE cycle between grants.
- Split: m1 granted to slave 1, len 8; slave_split after 3 beats; m2 requests slave 0, len 2.
  - m2 granted and completes; m2 is refused while targeting slave 1 during the split.
  - slave_resume: m1 regranted with 5 remaining beats ahead of pending m2.
- Timeout: TIMEOUT=10, m2 granted with no beat_done.
  - arb_timeout pulses at the 10th DATA cycle; grant drops; IDLE.
- Edge cases:
  - len=0 behaves as 1 beat.
  - slave_sel=3 is never granted.
  - Split and final beat in the same cycle: split wins, remaining=1.
- Reset mid-burst at beat 2: all outputs 0 next cycle; the next request from m1 is granted normally.
